axi_line_read_responder: RTL and testbench
==========================================

Name: axi_line_read_responder

Overview:
- Memory-side AXI read responder; the transmitting end of the R channel that the cache controller's fill path consumes.
- Accepts one AR request, fetches the addressed 512-bit line from a line-wide backing store, then serializes it as 64-bit R beats.
- Beat order is critical-word-first: WRAP bursts wrap within the 64 B line; INCR bursts are confined to the line.
- One outstanding transaction at a time.

Parameters:
- ID_W, 4, width of ARID/RID.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, synchronous, active-low
- arid_i  in  ID_W  read ID
- araddr_i  in  32  byte address; [31:6] selects the line, [5:3] is the start beat
- arlen_i  in  4  beats minus 1; only 0..7 are legal
- arsize_i  in  3  must be 3'b011 (8 B)
- arburst_i  in  2  2'b01 INCR, 2'b10 WRAP
- arvalid_i  in  1  AR valid
- arready_o  out  1  AR ready
- rid_o  out  ID_W  echoed ARID
- rdata_o  out  64  beat data
- rresp_o  out  2  2'b00 OKAY, 2'b10 SLVERR
- rlast_o  out  1  final beat
- rvalid_o  out  1  R valid
- rready_i  in  1  R ready
- line_rden_o  out  1  one-cycle line read request
- line_raddr_o  out  26  latched araddr[31:6]
- line_rdata_i  in  512  line data; beat k is bits [64k+63:64k]
- line_rvalid_i  in  1  line data valid, single-cycle pulse

Behaviour:
- States:
  - IDLE: arready_o=1. On arvalid_i & arready_o, latch id, araddr[31:6], offset=araddr[5:3], len and burst; set beat=0; evaluate err.
    - err=0: go to FETCH.
    - err=1: go to SEND.
  - FETCH: line_rden_o=1 only in the first FETCH cycle. Stay until line_rvalid_i=1, then capture line_rdata_i into a 512-bit buffer and go to SEND. line_rvalid_i in the same cycle as line_rden_o is legal (zero latency).
  - SEND: rvalid_o=1.
    - On rready_i: beat increments.
    - On rready_i & rlast_o: go to IDLE.
- err conditions (any one sets err):
  - arsize_i != 3'b011
  - arlen_i > 7
  - arburst_i not in {01, 10}
  - INCR with offset + arlen_i > 7
- Error response: no line read is issued. Beats = min(arlen_i, 15) + 1, all with rresp_o=SLVERR and rdata_o=0.
- Beat index: idx = (offset + beat) mod 8 (3-bit wrap).
- rdata_o = buffer[64*idx +: 64] when err=0, else 0.
- rlast_o = (beat == len) while in SEND. rid_o = latched id. rresp_o = 00 when err=0.
- R stability: while rvalid_o & !rready_i, rdata_o, rresp_o, rlast_o and rid_o hold stable.
- arready_o = (state == IDLE). It is low from the cycle after the AR handshake until the cycle after the final R handshake.
- Latency, normal path:
  - AR handshake at edge T → line_rden_o high in cycle T+1.
  - line_rvalid_i sampled at edge U → rvalid_o high from cycle U+1.
- Latency, error path: AR handshake at edge T → rvalid_o high in cycle T+1.
- Back-to-back bursts: minimum gap is one IDLE cycle between rlast handshake and the next AR acceptance.
- line_rvalid_i outside FETCH is ignored.
- Reset values: state IDLE, arready_o=1, rvalid_o=0, rlast_o=0, rdata_o=0, rresp_o=0, rid_o=0, line_rden_o=0, line_raddr_o=0, buffer=0, beat=0.
- Reset mid-operation: any state returns to IDLE on the next edge with rst_n low. The burst is abandoned with no further beats. A late line_rvalid_i is ignored.

Test Plan:
- WRAP, araddr=0x0000_1058, arlen=7, arid=5; line beat k = 0xA5A5_0000_0000_000k → line_raddr_o=0x41. R data order 3,4,5,6,7,0,1,2; rlast only on the 8th beat; rid=5; rresp=00 on all beats.
- Same WRAP request with rready_i toggling 1,0,0,1,… and line latency 4 → line_rden_o is a single pulse; rvalid_o 1 cycle after line_rvalid_i; rdata_o stable across stalls; exactly 8 handshakes.
- INCR, araddr offset 2, arlen=3 → beats 2,3,4,5, rlast on the 4th. INCR, offset 6, arlen=3 → no line_rden_o; 4 beats SLVERR, rdata 0.
- arsize=3'b010, arlen=0 → rvalid_o 1 cycle after the AR handshake; 1 beat SLVERR, rlast=1. arlen=9 → 10 SLVERR beats.
- rst_n low for 1 cycle after beat 3 of a WRAP burst; then line_rvalid_i pulses → next cycle rvalid_o=0, arready_o=1; stray pulse ignored. A new WRAP request at offset 0 returns beats 0..7 correctly.
- arvalid_i held high across two requests → second AR accepted only in the IDLE cycle after the first rlast handshake; zero-latency line_rvalid_i with line_rden_o gives rvalid_o 2 cycles after the AR handshake.

Source files
------------

// File: rtl/axi_line_read_responder_if.sv
// AXI read address/data channel bundle between a cache fill path (master)
// and the line read responder (slave). Signal suffixes are from the responder's view.
interface axi_line_read_responder_if #(
  parameter int ID_W = 4
);
  logic [ID_W-1:0] arid_i;
  logic [31:0]     araddr_i;
  logic [3:0]      arlen_i;
  logic [2:0]      arsize_i;
  logic [1:0]      arburst_i;
  logic            arvalid_i;
  logic            arready_o;

  logic [ID_W-1:0] rid_o;
  logic [63:0]     rdata_o;
  logic [1:0]      rresp_o;
  logic            rlast_o;
  logic            rvalid_o;
  logic            rready_i;

  modport slave (
    input  arid_i, araddr_i, arlen_i, arsize_i, arburst_i, arvalid_i, rready_i,
    output arready_o, rid_o, rdata_o, rresp_o, rlast_o, rvalid_o
  );

  modport master (
    output arid_i, araddr_i, arlen_i, arsize_i, arburst_i, arvalid_i, rready_i,
    input  arready_o, rid_o, rdata_o, rresp_o, rlast_o, rvalid_o
  );
endinterface

// File: rtl/axi_line_read_responder.sv
// Single-outstanding AXI read responder: fetches one 512-bit line and returns
// it as 64-bit beats, critical word first, wrapping inside the line.
module axi_line_read_responder #(
  parameter int ID_W = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  axi_line_read_responder_if.slave  axi,
  output logic                      line_rden_o,
  output logic [25:0]               line_raddr_o,
  input  logic [511:0]              line_rdata_i,
  input  logic                      line_rvalid_i
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    SEND  = 2'd2
  } state_t;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  state_t          r_state;
  logic            r_arready;
  logic            r_rvalid;
  logic            r_rden;
  logic [25:0]     r_line_addr;
  logic [ID_W-1:0] r_id;
  logic [2:0]      r_offset;
  logic [3:0]      r_len;
  logic            r_err;
  logic [3:0]      r_beat;
  logic [511:0]    r_buf;

  logic            w_err;
  logic [4:0]      w_incr_end;
  logic [2:0]      w_idx;
  logic            w_rlast;

  // Request legality is judged on the live AR fields so it can be latched
  // together with the rest of the request in the handshake cycle.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    w_err      = 1'b0;
    w_incr_end = {2'b00, axi.araddr_i[5:3]} + {1'b0, axi.arlen_i};
    if (axi.arsize_i != 3'b011)                                  w_err = 1'b1;
    if (axi.arlen_i > 4'd7)                                      w_err = 1'b1;
    if (axi.arburst_i != BURST_INCR && axi.arburst_i != BURST_WRAP) w_err = 1'b1;
    if (axi.arburst_i == BURST_INCR && w_incr_end > 5'd7)        w_err = 1'b1;
  end

  // 3-bit add wraps naturally inside the 8-beat line.
  assign w_idx   = r_offset + r_beat[2:0];
  assign w_rlast = (r_state == SEND) && (r_beat == r_len);

  assign axi.arready_o = r_arready;
  assign axi.rvalid_o  = r_rvalid;
  assign axi.rid_o     = r_id;
  assign axi.rlast_o   = w_rlast;
  assign axi.rresp_o   = r_err ? RESP_SLVERR : RESP_OKAY;
  assign axi.rdata_o   = r_err ? 64'd0 : r_buf[{w_idx, 6'd0} +: 64];

  assign line_rden_o   = r_rden;
  assign line_raddr_o  = r_line_addr;

  // R outputs derive only from registers that move on an R handshake, so
  // they hold steady for as long as the master stalls.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_arready   <= 1'b1;
      r_rvalid    <= 1'b0;
      r_rden      <= 1'b0;
      r_line_addr <= '0;
      r_id        <= '0;
      r_offset    <= '0;
      r_len       <= '0;
      r_err       <= 1'b0;
      r_beat      <= '0;
      // NOTE: the line buffer is cleared on reset so rdata_o reads zero out of reset.
      r_buf       <= '0;
    end else begin
      // NOTE: all state updates use non-blocking assignment so every register sees pre-edge values.
      case (r_state)
        IDLE: begin
          if (axi.arvalid_i) begin
            r_id        <= axi.arid_i;
            r_line_addr <= axi.araddr_i[31:6];
            r_offset    <= axi.araddr_i[5:3];
            r_len       <= axi.arlen_i;
            r_err       <= w_err;
            r_beat      <= '0;
            r_arready   <= 1'b0;
            if (w_err) begin
              r_state  <= SEND;
              r_rvalid <= 1'b1;
            end else begin
              r_state <= FETCH;
              r_rden  <= 1'b1;
            end
          end
        end

        FETCH: begin
          r_rden <= 1'b0;
          if (line_rvalid_i) begin
            r_buf    <= line_rdata_i;
            r_state  <= SEND;
            r_rvalid <= 1'b1;
          end
        end

        SEND: begin
          if (axi.rready_i) begin
            if (w_rlast) begin
              r_state   <= IDLE;
              r_rvalid  <= 1'b0;
              r_arready <= 1'b1;
            end else begin
              r_beat <= r_beat + 4'd1;
            end
          end
        end

        default: begin
          r_state   <= IDLE;
          r_arready <= 1'b1;
          r_rvalid  <= 1'b0;
          r_rden    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_axi_line_read_responder.sv
// Directed bench for axi_line_read_responder: a line-store model with
// programmable latency answers line reads; R beats are checked against it.
module tb_axi_line_read_responder;

  localparam int ID_W = 4;

  logic         clk;
  logic         rst_n;
  logic [511:0] line_data;
  logic         line_rvalid;
  logic         line_rden;
  logic [25:0]  line_raddr;

  axi_line_read_responder_if #(.ID_W(ID_W)) bus ();

  axi_line_read_responder #(.ID_W(ID_W)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .axi           (bus),
    .line_rden_o   (line_rden),
    .line_raddr_o  (line_raddr),
    .line_rdata_i  (line_data),
    .line_rvalid_i (line_rvalid)
  );

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  int lat = 1;
  int rden_cnt = 0;
  int rden_first_cyc = -1;
  int lrv_cyc = -1;
  bit stray_req = 0;

  int ar_cyc;
  int first_rv_cyc;
  int last_cyc;
  int r0;
  int hs1_last;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: observed no finish, required finish before time limit");
    $fatal(1, "watchdog expired");
  end

  // Line store: answers each line_rden_o pulse after 'lat' cycles (0 = same cycle).
  initial begin
    int  cnt;
    bit  pending;
    pending = 0;
    cnt = 0;
    line_rvalid = 1'b0;
    forever begin
      @(negedge clk);
      line_rvalid = 1'b0;
      if (line_rden) rden_cnt++;
      if (stray_req) begin
        line_rvalid = 1'b1;
        lrv_cyc = cyc;
        stray_req = 0;
      end else if (pending) begin
        if (cnt == 0) begin
          line_rvalid = 1'b1;
          lrv_cyc = cyc;
          pending = 0;
        end else begin
          cnt--;
        end
      end else if (line_rden) begin
        rden_first_cyc = cyc;
        if (lat == 0) begin
          line_rvalid = 1'b1;
          lrv_cyc = cyc;
        end else begin
          pending = 1;
          cnt = lat - 1;
        end
      end
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic fill_line(input logic [31:0] hi);
    for (int k = 0; k < 8; k++) line_data[64*k +: 64] = {hi, 32'(k)};
  endtask

  // Presents an AR request (called #1 after an edge) and waits for its handshake.
  task automatic do_ar(input logic [3:0] id, input logic [31:0] addr, input logic [3:0] len,
                       input logic [2:0] size, input logic [1:0] burst, input bit keep);
    bit hs;
    hs = 0;
    bus.arid_i    = id;
    bus.araddr_i  = addr;
    bus.arlen_i   = len;
    bus.arsize_i  = size;
    bus.arburst_i = burst;
    bus.arvalid_i = 1'b1;
    for (int w = 0; w < 100 && !hs; w++) begin
      if (bus.arready_o) begin
        hs = 1;
        ar_cyc = cyc;
      end
      @(posedge clk);
      #1;
    end
    check("ar_handshake", 64'(hs), 64'd1);
    if (!keep) bus.arvalid_i = 1'b0;
  endtask

  // Receives up to stop_at beats of an n-beat burst, checking every cycle
  // (stalled cycles recheck the same beat, which covers R stability).
  task automatic expect_burst(input int n, input int stop_at, input logic [3:0] id,
                              input logic [2:0] start, input logic err, input bit stall);
    int          b;
    int          phase;
    logic [2:0]  idx;
    logic [63:0] exp_d;
    logic        rdy;
    b = 0;
    phase = 0;
    for (int w = 0; w < 50 && !bus.rvalid_o; w++) begin
      @(posedge clk);
      #1;
    end
    first_rv_cyc = cyc;
    check("rvalid_rise", 64'(bus.rvalid_o), 64'd1);
    while (b < n && b < stop_at) begin
      idx   = start + 3'(b);
      exp_d = err ? 64'd0 : line_data[64*idx +: 64];
      check("rvalid", 64'(bus.rvalid_o), 64'd1);
      check("rdata", bus.rdata_o, exp_d);
      check("rresp", 64'(bus.rresp_o), err ? 64'd2 : 64'd0);
      check("rlast", 64'(bus.rlast_o), (b == n - 1) ? 64'd1 : 64'd0);
      check("rid", 64'(bus.rid_o), 64'(id));
      rdy = stall ? ((phase % 3) == 0) : 1'b1;
      phase++;
      bus.rready_i = rdy;
      @(posedge clk);
      #1;
      if (rdy) b++;
    end
    bus.rready_i = 1'b0;
    last_cyc = cyc;
    if (stop_at >= n) begin
      check("rvalid_after_last", 64'(bus.rvalid_o), 64'd0);
      check("arready_after_last", 64'(bus.arready_o), 64'd1);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    bus.arid_i = '0;
    bus.araddr_i = '0;
    bus.arlen_i = '0;
    bus.arsize_i = 3'b011;
    bus.arburst_i = 2'b01;
    bus.arvalid_i = 1'b0;
    bus.rready_i = 1'b0;
    fill_line(32'hA5A5_0000);

    repeat (2) @(posedge clk);
    #1;
    check("rst_arready", 64'(bus.arready_o), 64'd1);
    check("rst_rvalid", 64'(bus.rvalid_o), 64'd0);
    check("rst_rlast", 64'(bus.rlast_o), 64'd0);
    check("rst_rdata", bus.rdata_o, 64'd0);
    check("rst_rresp", 64'(bus.rresp_o), 64'd0);
    check("rst_rid", 64'(bus.rid_o), 64'd0);
    check("rst_line_rden", 64'(line_rden), 64'd0);
    check("rst_line_raddr", 64'(line_raddr), 64'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // WRAP at offset 3, 8 beats, line latency 2.
    lat = 2;
    r0 = rden_cnt;
    do_ar(4'd5, 32'h0000_1058, 4'd7, 3'b011, 2'b10, 0);
    check("wrap_rden_now", 64'(line_rden), 64'd1);
    check("wrap_arready_busy", 64'(bus.arready_o), 64'd0);
    check("wrap_raddr", 64'(line_raddr), 64'h41);
    expect_burst(8, 8, 4'd5, 3'd3, 1'b0, 0);
    check("wrap_rden_pulses", 64'(rden_cnt - r0), 64'd1);
    check("wrap_rden_latency", 64'(rden_first_cyc), 64'(ar_cyc + 1));
    check("wrap_rvalid_latency", 64'(first_rv_cyc), 64'(lrv_cyc + 1));

    // Same WRAP with line latency 4 and rready stalling 1,0,0.
    lat = 4;
    r0 = rden_cnt;
    do_ar(4'd5, 32'h0000_1058, 4'd7, 3'b011, 2'b10, 0);
    expect_burst(8, 8, 4'd5, 3'd3, 1'b0, 1);
    check("stall_rden_pulses", 64'(rden_cnt - r0), 64'd1);
    check("stall_rvalid_latency", 64'(first_rv_cyc), 64'(lrv_cyc + 1));
    check("stall_rden_idle", 64'(line_rden), 64'd0);

    // INCR offset 2, 4 beats: legal.
    lat = 1;
    r0 = rden_cnt;
    fill_line(32'h1234_0000);
    do_ar(4'd3, 32'h0000_2010, 4'd3, 3'b011, 2'b01, 0);
    check("incr_raddr", 64'(line_raddr), 64'h80);
    expect_burst(4, 4, 4'd3, 3'd2, 1'b0, 0);
    check("incr_rden_pulses", 64'(rden_cnt - r0), 64'd1);

    // INCR offset 6, 4 beats: crosses the line, SLVERR without a line read.
    r0 = rden_cnt;
    do_ar(4'd4, 32'h0000_2030, 4'd3, 3'b011, 2'b01, 0);
    expect_burst(4, 4, 4'd4, 3'd6, 1'b1, 0);
    check("incr_err_rden", 64'(rden_cnt - r0), 64'd0);
    check("incr_err_latency", 64'(first_rv_cyc), 64'(ar_cyc + 1));

    // Bad size, single beat.
    r0 = rden_cnt;
    do_ar(4'd6, 32'h0000_1000, 4'd0, 3'b010, 2'b01, 0);
    expect_burst(1, 1, 4'd6, 3'd0, 1'b1, 0);
    check("size_err_latency", 64'(first_rv_cyc), 64'(ar_cyc + 1));
    check("size_err_rden", 64'(rden_cnt - r0), 64'd0);

    // arlen 9: ten SLVERR beats.
    r0 = rden_cnt;
    do_ar(4'd7, 32'h0000_0000, 4'd9, 3'b011, 2'b01, 0);
    expect_burst(10, 10, 4'd7, 3'd0, 1'b1, 0);
    check("len_err_rden", 64'(rden_cnt - r0), 64'd0);

    // Reset after 3 beats of a WRAP burst, then a stray line pulse.
    lat = 1;
    fill_line(32'h5A5A_0000);
    do_ar(4'd9, 32'h0000_1058, 4'd7, 3'b011, 2'b10, 0);
    expect_burst(8, 3, 4'd9, 3'd3, 1'b0, 0);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    check("midrst_rvalid", 64'(bus.rvalid_o), 64'd0);
    check("midrst_arready", 64'(bus.arready_o), 64'd1);
    check("midrst_rlast", 64'(bus.rlast_o), 64'd0);
    r0 = rden_cnt;
    stray_req = 1;
    @(posedge clk);
    #1;
    check("stray_rvalid", 64'(bus.rvalid_o), 64'd0);
    check("stray_arready", 64'(bus.arready_o), 64'd1);
    check("stray_rden", 64'(line_rden), 64'd0);
    fill_line(32'hC3C3_0000);
    do_ar(4'd10, 32'h0000_3000, 4'd7, 3'b011, 2'b10, 0);
    check("post_rst_raddr", 64'(line_raddr), 64'hC0);
    expect_burst(8, 8, 4'd10, 3'd0, 1'b0, 0);
    check("post_rst_rden", 64'(rden_cnt - r0), 64'd1);

    // arvalid held across two requests, zero-latency line store.
    lat = 0;
    fill_line(32'h0F0F_0000);
    do_ar(4'd1, 32'h0000_4008, 4'd7, 3'b011, 2'b10, 1);
    bus.arid_i   = 4'd2;
    bus.araddr_i = 32'h0000_4000;
    check("hold_arready_busy", 64'(bus.arready_o), 64'd0);
    expect_burst(8, 8, 4'd1, 3'd1, 1'b0, 0);
    check("zero_lat_rvalid", 64'(first_rv_cyc), 64'(ar_cyc + 2));
    hs1_last = last_cyc;
    do_ar(4'd2, 32'h0000_4000, 4'd7, 3'b011, 2'b10, 0);
    check("b2b_accept_cycle", 64'(ar_cyc), 64'(hs1_last));
    expect_burst(8, 8, 4'd2, 3'd0, 1'b0, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
